// File: rtl/uart_pkg.sv
// Shared UART definitions: widths, framing state encoding and the buffered-byte payload.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LEN_W  = 10;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } rx_frame_state_e;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; a write into a full FIFO is accepted
// only when a read frees the head entry in the same cycle.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_fire,
    input  logic              rd_ready,
    output logic              rd_fire,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    assign empty   = (count == '0);
    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign rd_fire = rd_ready && !empty;
    assign wr_fire = wr_valid && (!full || rd_fire);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap modulo DEPTH since DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_fire) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clock) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_frame_buffer.sv
// Groups received UART bytes into frames of bytes_to_rx+1 and buffers them,
// tagged with a last-byte flag, for a valid/ready consumer.
module uart_rx_frame_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [LEN_W-1:0]  bytes_to_rx,
    input  logic              rx_data_valid,
    input  logic [BYTE_W-1:0] rx_data_byte,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              frame_done,
    output logic [ADDR_W:0]   fill_level,
    output logic              overflow,
    input  logic              clear_overflow
);

    rx_frame_state_e  state_q, state_d;
    logic [LEN_W-1:0] byte_idx_q, byte_idx_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic             is_last;
    logic             wr_fire;
    logic             rd_fire;
    logic             fifo_full;
    logic             fifo_empty;
    rx_entry_t        wr_entry;
    rx_entry_t        head_entry;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_idx_q  <= '0;
            frame_len_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            frame_len_q <= frame_len_d;
        end
    end

    // Framing: the frame length is captured on the first byte and held until the last.
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        frame_len_d = frame_len_q;
        is_last     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_data_valid) begin
                    frame_len_d = bytes_to_rx;
                    if (bytes_to_rx == '0) begin
                        is_last = 1'b1;
                    end else begin
                        byte_idx_d = LEN_W'(1);
                        state_d    = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (rx_data_valid) begin
                    if (byte_idx_q == frame_len_q) begin
                        is_last = 1'b1;
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Dropped bytes still advance framing, so frame_done and alignment survive overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= rx_data_valid && is_last;
            if (rx_data_valid && !wr_fire) overflow <= 1'b1;
            else if (clear_overflow)       overflow <= 1'b0;
        end
    end

    assign wr_entry.last = is_last;
    assign wr_entry.data = rx_data_byte;

    uart_sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .wr_valid (rx_data_valid),
        .wr_data  (wr_entry),
        .wr_fire  (wr_fire),
        .rd_ready (out_ready),
        .rd_fire  (rd_fire),
        .rd_data  (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fill_level)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head_entry.data;
    assign out_last  = head_entry.last;

endmodule
